// File: rtl/dest_reg_hazard_controller.sv
// dest_reg_hazard_controller
//
// Tracks the destination registers of the instructions in EX, MEM and WB and
// compares the decode-stage sources against them. It produces the decode
// stall/issue handshake, the registered EX operand-forward selects, and the
// per-stage destination addresses and WB write enable.
//
// Build option: define FORWARDING_EN to enable EX/MEM and MEM/WB forwarding.
// With forwarding, only a load-use hazard stalls. Without it, any dependency
// on EX or MEM stalls and the forward selects stay at 00.
//
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   id_*                  decode instruction: valid, sources, dest, load flag
//   flush                 squash the decode instruction (redirect)
//   stall, issue          combinational decode handshake
//   fwd_a_sel, fwd_b_sel  registered EX operand sources (00 rf, 01 EX/MEM, 10 MEM/WB)
//   ex_dest/mem_dest/wb_dest, wb_write_en   per-stage destination tracking
//   stall_count           saturating count of stall cycles
module dest_reg_hazard_controller #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic              id_rs_used,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic              id_rt_used,
  input  logic [ADDR_W-1:0] id_dest_addr,
  input  logic              id_writes,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic              issue,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [ADDR_W-1:0] ex_dest,
  output logic [ADDR_W-1:0] mem_dest,
  output logic [ADDR_W-1:0] wb_dest,
  output logic              wb_write_en,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dest;
    logic              is_load;
  } stage_t;

  localparam logic [1:0] SelRf    = 2'b00;
  localparam logic [1:0] SelExMem = 2'b01;
  localparam logic [1:0] SelMemWb = 2'b10;

  stage_t s1_q, s1_d, s2_q, s3_q;
  logic [1:0]       fwd_a_sel_q, fwd_a_sel_d;
  logic [1:0]       fwd_b_sel_q, fwd_b_sel_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic rs_s1, rs_s2, rt_s1, rt_s2;
  logic hazard;

  // $0 never matches; a producer writing $0 is also tracked as invalid.
  function automatic logic src_match(input logic used, input logic [ADDR_W-1:0] addr,
                                     input stage_t st);
    return used && (addr != '0) && st.valid && (st.dest == addr);
  endfunction

  always_comb begin
    rs_s1 = src_match(id_rs_used, id_rs_addr, s1_q);
    rs_s2 = src_match(id_rs_used, id_rs_addr, s2_q);
    rt_s1 = src_match(id_rt_used, id_rt_addr, s1_q);
    rt_s2 = src_match(id_rt_used, id_rt_addr, s2_q);
    // WB matches are never hazards: the register file is write-first.
`ifdef FORWARDING_EN
    hazard = (rs_s1 || rt_s1) && s1_q.is_load;
`else
    hazard = rs_s1 || rs_s2 || rt_s1 || rt_s2;
`endif
    // Flush wins over stall.
    stall = id_valid && hazard && !flush;
    issue = id_valid && !stall && !flush;
  end

  always_comb begin
    s1_d = '0;
    if (issue) begin
      s1_d.valid   = id_writes && (id_dest_addr != '0);
      s1_d.dest    = id_dest_addr;
      s1_d.is_load = id_is_load;
    end

    fwd_a_sel_d = SelRf;
    fwd_b_sel_d = SelRf;
`ifdef FORWARDING_EN
    // Youngest producer wins.
    if (issue) begin
      if (rs_s1)      fwd_a_sel_d = SelExMem;
      else if (rs_s2) fwd_a_sel_d = SelMemWb;
      if (rt_s1)      fwd_b_sel_d = SelExMem;
      else if (rt_s2) fwd_b_sel_d = SelMemWb;
    end
`endif

    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q          <= '0;
      s2_q          <= '0;
      s3_q          <= '0;
      fwd_a_sel_q   <= SelRf;
      fwd_b_sel_q   <= SelRf;
      stall_count_q <= '0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      fwd_a_sel_q   <= fwd_a_sel_d;
      fwd_b_sel_q   <= fwd_b_sel_d;
      stall_count_q <= stall_count_d;
    end
  end

  // The load flag is irrelevant once an instruction reaches WB.
  logic unused_s3_is_load;
  assign unused_s3_is_load = s3_q.is_load;

  assign ex_dest     = s1_q.dest;
  assign mem_dest    = s2_q.dest;
  assign wb_dest     = s3_q.dest;
  assign wb_write_en = s3_q.valid;
  assign fwd_a_sel   = fwd_a_sel_q;
  assign fwd_b_sel   = fwd_b_sel_q;
  assign stall_count = stall_count_q;

endmodule

// File: doc/dest_reg_hazard_controller.md
Name: dest_reg_hazard_controller

Overview:
- Tracks destination register addresses of in-flight instructions through the EX, MEM and WB stages of the MIPS32 pipeline.
- Compares decode-stage source addresses against them and generates stall, issue and operand-forward selects.
- Sits between decode and the EX-stage operand muxes.
- Supplies the per-stage destination addresses and write enable used by the register-file write port.

Parameters:
ADDR_W, 5, register address width (32 GPRs)
CNT_W, 8, width of saturating stall-cycle counter

Ports:
clock  input  1  pipeline clock, rising edge
reset_n  input  1  asynchronous active-low reset
id_valid  input  1  valid instruction in decode
id_rs_addr  input  ADDR_W  source A register address
id_rs_used  input  1  instruction reads rs
id_rt_addr  input  ADDR_W  source B register address
id_rt_used  input  1  instruction reads rt
id_dest_addr  input  ADDR_W  destination register address (already muxed rd/rt)
id_writes  input  1  instruction writes a register
id_is_load  input  1  instruction is a load
flush  input  1  squash decode instruction (branch/jump redirect)
stall  output  1  hold PC and IF/ID register (combinational)
issue  output  1  decode instruction advances to EX this cycle (combinational)
fwd_a_sel  output  2  EX operand A source: 00 regfile, 01 EX/MEM, 10 MEM/WB (registered)
fwd_b_sel  output  2  EX operand B source, same encoding (registered)
ex_dest  output  ADDR_W  destination address of instruction in EX
mem_dest  output  ADDR_W  destination address of instruction in MEM
wb_dest  output  ADDR_W  destination address of instruction in WB
wb_write_en  output  1  WB stage writes register file
stall_count  output  CNT_W  saturating count of stall cycles

Behaviour:
- Three stage entries S1 (EX), S2 (MEM), S3 (WB), each {valid, dest, is_load}. Every rising edge:
  - S3 <= S2, S2 <= S1.
  - S1 <= issue ? {id_writes && id_dest_addr != 0, id_dest_addr, id_is_load} : bubble (valid = 0).
- Outputs: ex_dest = S1.dest, mem_dest = S2.dest, wb_dest = S3.dest, wb_write_en = S3.valid.
- Source match: src_used && src_addr != 0 && Sk.valid && Sk.dest == src_addr.
  - Register $0 never matches.
  - S3 matches are not hazards: the register file is write-first within the cycle.
- stall = id_valid && hazard && !flush.
- issue = id_valid && !stall && !flush.
- Flush wins over stall. On flush a bubble enters S1, stall = 0 and issue = 0.
- Forward selects:
  - Latched on the edge when issue = 1, to 00 otherwise.
  - Valid for the instruction then in EX.
  - Youngest producer wins: an S1 match gives 01; else an S2 match gives 10; else 00.
- stall_count increments on each cycle with stall = 1, saturating at 2^CNT_W-1.
- Reset (reset_n = 0, asynchronous, any time including mid-stall):
  - All Sk cleared to valid = 0, dest = 0.
  - fwd_a_sel = fwd_b_sel = 00, stall_count = 0.
  - Hence ex_dest/mem_dest/wb_dest = 0 and wb_write_en = 0.
  - stall/issue follow their equations with cleared state.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined:
  - hazard = match S1 && S1.is_load (load-use only).
  - Forward selects are generated as above.
  - Load-use costs exactly 1 stall cycle, then issue with select 10.
- Undefined:
  - hazard = match S1 || match S2.
  - fwd_a_sel and fwd_b_sel are held at 00.
  - Distance-1 dependency stalls 2 cycles; distance-2 stalls 1 cycle.

Test Plan:
- Async reset: drive traffic, pull reset_n low between edges -> ex_dest/mem_dest/wb_dest = 0, wb_write_en = 0, fwd sels 00, stall_count = 0 immediately, before next edge.
- FORWARDING_EN, back-to-back ALU: issue writes $3, next cycle id_rs_addr = 3 -> stall = 0, issue = 1, fwd_a_sel = 01 after edge. Next cycle, third instruction with rt = 3 -> fwd_b_sel = 10.
- FORWARDING_EN, load-use: lw writes $5, next cycle id_rt_addr = 5 -> stall = 1 for 1 cycle. Then issue = 1, fwd_b_sel = 10, stall_count = 1.
- Forwarding off: add writes $7, consumer rs = 7 next cycle -> stall = 1 for 2 cycles, then issue with fwd_a_sel = 00. wb_write_en = 1, wb_dest = 7 on the cycle issue asserts.
- $0 handling: producer id_dest_addr = 0 with id_writes = 1, consumer rs = rt = 0 -> no stall, sels 00, wb_write_en stays 0.
- Flush during load-use stall: assert flush while stall = 1 -> stall = 0, issue = 0, bubble in S1. stall_count unchanged that cycle; saturation checked by forcing 300 stall cycles -> stall_count = 255.
